// File: rtl/bp_stream_pump_in_gen2_pkg.sv
// Shared types and helpers for the BedRock inbound/outbound stream pumps.
//   - BedRock memory header (payload, size, addr, msg_type) and its enums
//   - pump FSM state enum
//   - burst order enum (wrap / linear)
//   - stream_beats_lg: log2 of beats in a message, clamped to the block
//   - stream_beat_addr: address of a given beat within a burst
package bp_stream_pump_in_gen2_pkg;

  localparam int unsigned paddr_width_p       = 40;
  localparam int unsigned mem_payload_width_p = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [mem_payload_width_p-1:0] payload;
    bp_bedrock_msg_size_e           size;
    logic [paddr_width_p-1:0]       addr;
    bp_bedrock_mem_type_e           msg_type;
  } bp_bedrock_mem_header_s;

  typedef enum logic {
    e_pump_idle,
    e_pump_stream
  } pump_state_e;

  typedef enum logic {
    e_stream_wrap,
    e_stream_linear
  } stream_order_e;

  // log2(num_beats): num_beats = max(bytes/beat_bytes, 1), clamped to block words
  function automatic logic [3:0] stream_beats_lg(input logic [2:0] size,
                                                 input logic [3:0] data_lg,
                                                 input logic [3:0] words_lg);
    logic [3:0] s;
    logic [3:0] r;
    s = {1'b0, size};
    if (s <= data_lg) r = '0;
    else              r = s - data_lg;
    if (r > words_lg) r = words_lg;
    return r;
  endfunction

  // Beat field lives at [data_lg +: beats_lg]. Wrap keeps header byte offset
  // and rotates from the critical beat; linear counts from the aligned base.
  function automatic logic [paddr_width_p-1:0] stream_beat_addr(
      input logic [paddr_width_p-1:0] addr,
      input logic [3:0]               data_lg,
      input logic [3:0]               beats_lg,
      input logic [7:0]               cnt,
      input stream_order_e            mode);
    logic [paddr_width_p-1:0] one;
    logic [paddr_width_p-1:0] byte_mask;
    logic [paddr_width_p-1:0] beat_mask;
    logic [paddr_width_p-1:0] field;
    logic [paddr_width_p-1:0] res;
    one       = paddr_width_p'(1);
    byte_mask = (one << data_lg) - one;
    beat_mask = ((one << beats_lg) - one) << data_lg;
    if (mode == e_stream_wrap) begin
      field = ((addr >> data_lg) + paddr_width_p'(cnt)) << data_lg;
      res   = (addr & ~beat_mask) | (field & beat_mask);
    end else begin
      field = paddr_width_p'(cnt) << data_lg;
      res   = (addr & ~beat_mask & ~byte_mask) | (field & beat_mask);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_stream_addr_gen.sv
// Combinational beat-address generator shared by the inbound and outbound
// stream pumps.
//   addr_i     : base address (header address with critical offset)
//   beats_lg_i : log2 of beats in the burst
//   cnt_i      : beat index within the burst
//   mode_i     : wrap (critical-word-first) or linear order
//   addr_o     : address of beat cnt_i
module bp_stream_addr_gen
  import bp_stream_pump_in_gen2_pkg::*;
#(
  parameter logic [3:0] data_lg_p = 4'd3
) (
  input  logic [paddr_width_p-1:0] addr_i,
  input  logic [3:0]               beats_lg_i,
  input  logic [7:0]               cnt_i,
  input  stream_order_e            mode_i,
  output logic [paddr_width_p-1:0] addr_o
);

  always_comb begin
    addr_o = stream_beat_addr(addr_i, data_lg_p, beats_lg_i, cnt_i, mode_i);
  end

endmodule

// File: rtl/bp_stream_pump_in_gen2.sv
// Inbound BedRock stream pump, second generation. Buffers bus beats in a
// small FIFO (no bypass) and presents one beat per cycle to a consuming FSM
// with per-beat address and index. Burst order per msg_type: wrap or linear.
//   clk_i / reset_n_i       : clock, asynchronous active-low reset
//   mem_*_i, mem_ready_and_o: bus-side stream input
//   fsm_*_o, fsm_ready_and_i: FSM-side beat output
//   stream_new_o            : first beat of a streamed message presented
//   stream_done_o           : last beat of a message accepted
//   err_o                   : sticky last-bit protocol error
// Optional: define BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN to store mem_last_i
// and flag last-bit mismatches on err_o; otherwise err_o is 0.
module bp_stream_pump_in_gen2
  import bp_stream_pump_in_gen2_pkg::*;
#(
  parameter int unsigned stream_data_width_p = 64,
  parameter int unsigned block_width_p       = 512,
  parameter int unsigned fifo_els_p          = 2,
  parameter logic [15:0] stream_mask_p       = '0,
  parameter logic [15:0] linear_mask_p       = '0,
  localparam int unsigned stream_words_lp = block_width_p / stream_data_width_p,
  localparam int unsigned cnt_width_lp    = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  bp_bedrock_mem_header_s         mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  input  logic                           mem_last_i,
  output logic                           mem_ready_and_o,
  output bp_bedrock_mem_header_s         fsm_base_header_o,
  output logic [paddr_width_p-1:0]       fsm_addr_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic [cnt_width_lp-1:0]        fsm_cnt_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_ready_and_i,
  output logic                           stream_new_o,
  output logic                           stream_done_o,
  output logic                           err_o
);

  localparam int unsigned ptr_width_lp    = $clog2(fifo_els_p);
  localparam int unsigned fill_width_lp   = $clog2(fifo_els_p + 1);
  localparam int unsigned offset_width_lp = $clog2(block_width_p / 8);
  localparam logic [3:0]  data_lg_lp      = 4'($clog2(stream_data_width_p / 8));
  localparam logic [3:0]  words_lg_lp     = 4'($clog2(stream_words_lp));
  localparam logic [fill_width_lp-1:0] fifo_els_lp = fill_width_lp'(fifo_els_p);
  localparam logic [ptr_width_lp-1:0]  ptr_max_lp  = ptr_width_lp'(fifo_els_p - 1);

  // ---------------- input FIFO ----------------
  bp_bedrock_mem_header_s         hdr_mem_q  [fifo_els_p];
  bp_bedrock_mem_header_s         hdr_mem_d  [fifo_els_p];
  logic [stream_data_width_p-1:0] data_mem_q [fifo_els_p];
  logic [stream_data_width_p-1:0] data_mem_d [fifo_els_p];
`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
  logic                           last_mem_q [fifo_els_p];
  logic                           last_mem_d [fifo_els_p];
`endif
  logic [ptr_width_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [fill_width_lp-1:0] fill_q, fill_d;
  logic enq, deq;

  // Ready is held low during reset and never looks at the dequeue side.
  assign mem_ready_and_o = reset_n_i & (fill_q != fifo_els_lp);
  assign fsm_v_o         = (fill_q != '0);
  assign enq             = mem_v_i & mem_ready_and_o;
  assign deq             = fsm_v_o & fsm_ready_and_i;

  always_comb begin
    hdr_mem_d  = hdr_mem_q;
    data_mem_d = data_mem_q;
`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
    last_mem_d = last_mem_q;
`endif
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (enq) begin
      hdr_mem_d[wptr_q]  = mem_header_i;
      data_mem_d[wptr_q] = mem_data_i;
`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
      last_mem_d[wptr_q] = mem_last_i;
`endif
      wptr_d = (wptr_q == ptr_max_lp) ? '0 : wptr_q + ptr_width_lp'(1);
    end
    if (deq) begin
      rptr_d = (rptr_q == ptr_max_lp) ? '0 : rptr_q + ptr_width_lp'(1);
    end
    case ({enq, deq})
      2'b10:   fill_d = fill_q + fill_width_lp'(1);
      2'b01:   fill_d = fill_q - fill_width_lp'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    hdr_mem_q  <= hdr_mem_d;
    data_mem_q <= data_mem_d;
`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
    last_mem_q <= last_mem_d;
`endif
  end

  // ---------------- head decode ----------------
  bp_bedrock_mem_header_s     head_hdr;
  bp_bedrock_mem_header_s     base_hdr;
  logic [3:0]                 beats_lg;
  logic                       is_stream;
  stream_order_e              order;
  logic [cnt_width_lp-1:0]    last_cnt;
  logic                       at_last;
  logic                       beat_last;
  logic [paddr_width_p-1:0]   gen_addr;

  pump_state_e                state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [offset_width_lp-1:0] critical_q, critical_d;

  assign head_hdr  = hdr_mem_q[rptr_q];
  assign beats_lg  = stream_beats_lg(head_hdr.size, data_lg_lp, words_lg_lp);
  assign is_stream = stream_mask_p[head_hdr.msg_type] & (beats_lg != '0);
  assign order     = linear_mask_p[head_hdr.msg_type] ? e_stream_linear : e_stream_wrap;
  assign last_cnt  = cnt_width_lp'((16'd1 << beats_lg) - 16'd1);
  assign at_last   = (state_q == e_pump_stream) & (cnt_q == last_cnt);
  assign beat_last = ~is_stream | at_last;

  // Mid-burst the base header carries the critical offset latched from the
  // first beat; on the first beat it is the head header itself.
  always_comb begin
    base_hdr = head_hdr;
    if (state_q == e_pump_stream) begin
      base_hdr.addr[offset_width_lp-1:0] = critical_q;
    end
  end

  bp_stream_addr_gen #(
    .data_lg_p(data_lg_lp)
  ) addr_gen (
    .addr_i    (base_hdr.addr),
    .beats_lg_i(beats_lg),
    .cnt_i     (8'(cnt_q)),
    .mode_i    (order),
    .addr_o    (gen_addr)
  );

  assign fsm_base_header_o = base_hdr;
  assign fsm_addr_o        = is_stream ? gen_addr : head_hdr.addr;
  assign fsm_data_o        = data_mem_q[rptr_q];
  assign fsm_cnt_o         = cnt_q;

  // ---------------- beat FSM ----------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    critical_d    = critical_q;
    stream_new_o  = 1'b0;
    stream_done_o = 1'b0;
    case (state_q)
      e_pump_idle: begin
        stream_new_o = fsm_v_o & is_stream;
        if (deq) begin
          critical_d = head_hdr.addr[offset_width_lp-1:0];
          if (is_stream) begin
            state_d = e_pump_stream;
            cnt_d   = cnt_width_lp'(1);
          end else begin
            stream_done_o = 1'b1;
          end
        end
      end
      e_pump_stream: begin
        if (deq) begin
          if (cnt_q == last_cnt) begin
            stream_done_o = 1'b1;
            cnt_d         = '0;
            state_d       = e_pump_idle;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
      end
      default: state_d = e_pump_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_pump_idle;
      cnt_q      <= '0;
      critical_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      critical_q <= critical_d;
    end
  end

  // ---------------- protocol check ----------------
`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (deq & (last_mem_q[rptr_q] != beat_last));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_check;
  assign unused_check = mem_last_i ^ beat_last;
  assign err_o        = 1'b0;
`endif

endmodule
